// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU subsystem: word/address widths and the
// DMA copy engine state encoding.
package cpu24_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 24;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2,
        DMA_DONE  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_copy_engine.sv
// Word-at-a-time memory-to-memory copy engine driving a single-port DataMemory:
// one read cycle then one write cycle per word, ascending addresses.
module dma_copy_engine
    import cpu24_pkg::*;
#(
    parameter int unsigned DATA_W = cpu24_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu24_pkg::ADDR_W,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] data_reg;

    assign words_done = count;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= DMA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DMA_IDLE: begin
                if (start) begin
                    state_nxt = (length == '0) ? DMA_DONE : DMA_READ;
                end
            end
            DMA_READ:  state_nxt = DMA_WRITE;
            DMA_WRITE: state_nxt = (remaining == LEN_W'(1)) ? DMA_DONE : DMA_READ;
            DMA_DONE:  state_nxt = DMA_IDLE;
            default:   state_nxt = DMA_IDLE;
        endcase
    end

    // Memory-port and status decode; address/data are forced to zero when idle
    // so the shared memory bus sees no stale values.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            DMA_IDLE: busy = 1'b0;
            DMA_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = src_ptr;
            end
            DMA_WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = data_reg;
            end
            DMA_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Transfer datapath: request latch, pointers, word counters, data buffer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            count     <= '0;
            data_reg  <= '0;
        end else begin
            case (state)
                DMA_IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (length != '0) begin
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            remaining <= length;
                        end
                    end
                end
                DMA_READ: data_reg <= mem_rdata;
                DMA_WRITE: begin
                    src_ptr   <= src_ptr + ADDR_W'(1);
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    count     <= count + LEN_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine with a behavioural DataMemory and a
// sequential copy reference model.
module tb_dma_copy_engine;
    import cpu24_pkg::*;

    localparam int unsigned LEN_W     = 8;
    localparam int          MEM_WORDS = 1024;
    localparam int          TRACE     = 8192;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] src_addr;
    logic [23:0] dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic [7:0]  words_done;
    logic [23:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [23:0] mem_rdata;

    always #5 clock = ~clock;

    dma_copy_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    // DataMemory stand-in: 1024 words aliased on the low address bits
    logic [23:0] mem     [MEM_WORDS];
    logic [23:0] ref_mem [MEM_WORDS];
    logic        fill = 1'b0;
    logic        pl_en = 1'b0;
    logic [23:0] pl_addr = '0;
    logic [23:0] pl_data = '0;
    int          fill_seed = 0;

    assign mem_rdata = mem[mem_addr[9:0]];

    function automatic logic [23:0] pat(input int i, input int seed);
        return 24'((i * 40503) ^ (seed * 7919) ^ (i << 7));
    endfunction

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= pat(i, fill_seed);
        end else if (pl_en) begin
            mem[pl_addr[9:0]] <= pl_data;
        end else if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    // Bus monitor: write trace, read/done counts, protocol violations
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          viol = 0;
    logic [23:0] wr_addr [TRACE];
    logic [23:0] wr_data [TRACE];

    always @(posedge clock) begin
        if (mem_write && wr_cnt < TRACE) begin
            wr_addr[wr_cnt] <= mem_addr;
            wr_data[wr_cnt] <= mem_wdata;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (mem_read) rd_cnt++;
        if ((mem_read && mem_write) ||
            (!mem_read && !mem_write && mem_addr != 24'd0) ||
            (!mem_write && mem_wdata != 24'd0) ||
            ((!busy || done) && (mem_read || mem_write)))
            viol++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int seed);
        @(negedge clock);
        fill_seed = seed;
        fill      = 1'b1;
        @(negedge clock);
        fill = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i, seed);
    endtask

    task automatic poke(input logic [23:0] a, input logic [23:0] d);
        @(negedge clock);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clock);
        pl_en = 1'b0;
        ref_mem[a[9:0]] = d;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // One complete transfer checked against the sequential copy model
    task automatic do_copy(input int id, input logic [23:0] s, input logic [23:0] d,
                           input int n, input int exp_done, input bit noise);
        logic [23:0] ea [$];
        logic [23:0] ed [$];
        logic [23:0] sa;
        logic [23:0] da;
        int w0, r0, d0, done_cyc, busy_cyc, lim, mism;
        for (int i = 0; i < n; i++) begin
            sa = 24'(s + 24'(i));
            da = 24'(d + 24'(i));
            ea.push_back(da);
            ed.push_back(ref_mem[sa[9:0]]);
            ref_mem[da[9:0]] = ref_mem[sa[9:0]];
        end
        @(negedge clock);
        src_addr = s;
        dst_addr = d;
        length   = 8'(n);
        start    = 1'b1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        d0 = done_cnt;
        @(negedge clock);
        start    = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        lim      = 2 * n + 8;
        for (int c = 1; c <= lim; c++) begin
            if (c > 1) @(negedge clock);
            if (busy) busy_cyc++;
            if (done && done_cyc < 0) done_cyc = c;
            if (!busy) break;
            if (noise) begin
                src_addr = 24'($urandom);
                dst_addr = 24'($urandom);
                length   = 8'($urandom);
                start    = (c < 2 * n) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_cycle", id), 32'(done_cyc), 32'(exp_done));
        chk($sformatf("v%0d_busy_cycles", id), 32'(busy_cyc), 32'(exp_done));
        chk($sformatf("v%0d_done_pulses", id), 32'(done_cnt - d0), 32'd1);
        chk($sformatf("v%0d_writes", id), 32'(wr_cnt - w0), 32'(n));
        chk($sformatf("v%0d_reads", id), 32'(rd_cnt - r0), 32'(n));
        mism = 0;
        for (int i = 0; i < n; i++)
            if (w0 + i >= TRACE || wr_addr[w0 + i] !== ea[i] || wr_data[w0 + i] !== ed[i]) mism++;
        chk($sformatf("v%0d_write_trace", id), 32'(mism), 32'd0);
        chk($sformatf("v%0d_mem_image", id), 32'(mem_diffs()), 32'd0);
        repeat (2) @(negedge clock);
        chk($sformatf("v%0d_words_done", id), 32'(words_done), 32'(n));
    endtask

    typedef struct {
        logic [23:0]      s;
        logic [23:0]      d;
        int               n;
        int               exp_done;
        int               npre;
        logic [3:0][23:0] pa;
        logic [3:0][23:0] pd;
        int               nchk;
        logic [2:0][23:0] ca;
        logic [2:0][23:0] cd;
    } vec_t;

    vec_t vec [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] ta;
        int w0, d0, rn;

        vec[0] = '{s: 24'd2, d: 24'd10, n: 2, exp_done: 5, npre: 2, pa: '0, pd: '0, nchk: 2, ca: '0, cd: '0};
        vec[0].pa[0] = 24'd2;  vec[0].pd[0] = 24'd7;
        vec[0].pa[1] = 24'd3;  vec[0].pd[1] = 24'd9;
        vec[0].ca[0] = 24'd10; vec[0].cd[0] = 24'd7;
        vec[0].ca[1] = 24'd11; vec[0].cd[1] = 24'd9;
        vec[1] = '{s: 24'd5, d: 24'd6, n: 0, exp_done: 1, npre: 0, pa: '0, pd: '0, nchk: 0, ca: '0, cd: '0};
        vec[2] = '{s: 24'hFFFFFF, d: 24'd20, n: 2, exp_done: 5, npre: 2, pa: '0, pd: '0, nchk: 2, ca: '0, cd: '0};
        vec[2].pa[0] = 24'hFFFFFF; vec[2].pd[0] = 24'd5;
        vec[2].pa[1] = 24'd0;      vec[2].pd[1] = 24'd6;
        vec[2].ca[0] = 24'd20;     vec[2].cd[0] = 24'd5;
        vec[2].ca[1] = 24'd21;     vec[2].cd[1] = 24'd6;
        vec[3] = '{s: 24'd0, d: 24'd1, n: 3, exp_done: 7, npre: 4, pa: '0, pd: '0, nchk: 3, ca: '0, cd: '0};
        for (int i = 0; i < 4; i++) begin
            vec[3].pa[i] = 24'(i);
            vec[3].pd[i] = 24'(i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            vec[3].ca[i] = 24'(i + 1);
            vec[3].cd[i] = 24'd1;
        end
        vec[4] = '{s: 24'd300, d: 24'd600, n: 255, exp_done: 511, npre: 0, pa: '0, pd: '0, nchk: 0, ca: '0, cd: '0};

        reset_n  = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_en", 32'({mem_read, mem_write}), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset_words_done", 32'(words_done), 32'd0);
        fill_mem(1);
        @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vec[v].npre; k++) poke(vec[v].pa[k], vec[v].pd[k]);
            do_copy(v, vec[v].s, vec[v].d, vec[v].n, vec[v].exp_done, 1'b0);
            for (int k = 0; k < vec[v].nchk; k++) begin
                ta = vec[v].ca[k];
                chk($sformatf("v%0d_word%0d", v, k), 32'(mem[ta[9:0]]), 32'(vec[v].cd[k]));
            end
        end

        // Competing start requests and input churn while busy
        do_copy(10, 24'd50, 24'd80, 5, 11, 1'b1);

        // Reset during the second WRITE of a 4-word copy
        @(negedge clock);
        src_addr = 24'd40;
        dst_addr = 24'd60;
        length   = 8'd4;
        start    = 1'b1;
        w0 = wr_cnt;
        d0 = done_cnt;
        ref_mem[60] = ref_mem[40];
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_in_write", 32'(mem_write), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk("rst_writes", 32'(wr_cnt - w0), 32'd1);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mem_image", 32'(mem_diffs()), 32'd0);
        do_copy(11, 24'd70, 24'd90, 3, 7, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 20; t++) begin
            logic [23:0] rs;
            logic [23:0] rd;
            if (t % 5 == 0) fill_mem(t + 11);
            rs = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 1023));
            rd = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 1023));
            if (t == 7) rs = 24'hFFFFF0;
            if (t == 13) rd = 24'hFFFFFA;
            rn = $urandom_range(0, 40);
            do_copy(100 + t, rs, rd, rn, (rn == 0) ? 1 : 2 * rn + 1, 1'($urandom_range(0, 1)));
        end

        chk("protocol", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter DATA_W, default 24, data word width; SHALL match the DataMemory word.
REQ-002 Parameter ADDR_W, default 24, memory address width.
REQ-003 Parameter LEN_W, default 8, transfer-length width in words.
REQ-004 clock  in  1  single clock, all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a copy; sampled only in IDLE.
REQ-007 src_addr  in  ADDR_W  first source word address.
REQ-008 dst_addr  in  ADDR_W  first destination word address.
REQ-009 length  in  LEN_W  number of words to copy; 0 = no-op.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse at transfer completion.
REQ-012 words_done  out  LEN_W  count of words written in the current or last transfer.
REQ-013 mem_addr  out  ADDR_W  address to DataMemory.
REQ-014 mem_wdata  out  DATA_W  write data to DataMemory.
REQ-015 mem_write  out  1  DataMemory write enable; memory writes on rising clock edge.
REQ-016 mem_read  out  1  DataMemory read enable; mem_rdata is valid combinationally in the same cycle.
REQ-017 mem_rdata  in  DATA_W  read data from DataMemory.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE, DONE, held in a registered state variable.
REQ-019 IDLE: start=1 with length!=0 -> latch src_addr, dst_addr, and length; clear words_done; go to READ.
REQ-020 IDLE: start=1 with length=0 -> go to DONE; no memory access; words_done cleared.
REQ-021 READ: mem_read=1, mem_write=0, mem_addr=src pointer; at the edge, capture mem_rdata into the data register; go to WRITE.
REQ-022 WRITE: mem_write=1, mem_read=0, mem_addr=dst pointer, mem_wdata=data register; at the edge, increment both pointers, increment words_done, and decrement remaining.
REQ-023 WRITE exit: remaining==1 -> DONE; otherwise -> READ.
REQ-024 DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
REQ-025 mem_read and mem_write SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-026 mem_addr and mem_wdata SHALL be 0 whenever the corresponding enable is low.
REQ-027 Throughput: 2 cycles per word; done is high in cycle 2N+1 after the start-sampling edge for N>=1, and in cycle 1 for N=0.
REQ-028 Pointers SHALL increment modulo 2^ADDR_W; 24'hFFFFFF wraps to 0 without error.
REQ-029 Copy order SHALL be ascending and word-at-a-time; overlapping regions are copied with read-before-write per word and no overlap detection.
REQ-030 start while busy SHALL be ignored; input changes after latching SHALL not affect the transfer.
REQ-031 length=2^LEN_W-1 SHALL complete correctly; words_done reaches 255.
REQ-032 words_done SHALL hold its final value until the next accepted start.

Reset
REQ-033 reset_n=0 SHALL immediately force state=IDLE, busy=0, done=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, words_done=0, and clear pointers and the data register.
REQ-034 Reset asserted mid-transfer SHALL abort with no further memory write and no done pulse; words already written remain in memory.
REQ-035 After reset_n rises, the first accepted start SHALL be on the first rising edge with start=1.

Structure
REQ-036 Shared package cpu24_pkg SHALL hold DATA_W=24, ADDR_W=24, and the dma state encoding (IDLE=0, READ=1, WRITE=2, DONE=3).
REQ-037 Single module, no sub-modules; benches instantiate it alongside the existing DataMemory, connecting mem_* ports directly to Adresa/WriteData/MemWrite/MemRead/ReadData.

Verification
REQ-038 Preload mem[2]=7, mem[3]=9; start, src=2, dst=10, len=2 -> mem[10]=7, mem[11]=9; done in cycle 5; words_done=2.
REQ-039 start with len=0 -> done in cycle 1, busy high 1 cycle, mem_read/mem_write never asserted.
REQ-040 src=24'hFFFFFF, dst=20, len=2, mem[FFFFFF]=5, mem[0]=6 -> mem[20]=5, mem[21]=6.
REQ-041 Second start pulsed mid-transfer with different src -> ignored; result equals the first request only.
REQ-042 reset_n low during the 2nd WRITE of a len=4 copy -> only the 1st word is written, no done pulse, busy=0 immediately.
REQ-043 Overlap: src=0, dst=1, len=3, mem[0..3]=1,2,3,4 -> mem[1..3]=1,1,1 (forward propagation).
